accum_lanes: RTL and testbench



---
 rtl/accum_pkg.sv | 25 ++
 rtl/accum_lane.sv | 50 +++++
 rtl/accum_lanes.sv | 92 +++++++++
 tb/tb_accum_lanes.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/accum_pkg.sv
// Shared types and helpers for the multi-lane framed accumulator.
// Saturation bounds are returned 64 bits wide; callers size-cast to their accumulator width.
package accum_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    ACCUM = 1'b1
  } state_e;

  function automatic logic signed [63:0] ACCUM_SAT_MAX(input int w);
    return (64'sd1 <<< (w - 1)) - 64'sd1;
  endfunction

  function automatic logic signed [63:0] ACCUM_SAT_MIN(input int w);
    return -(64'sd1 <<< (w - 1));
  endfunction

  // Sign-extend the low w bits of x to 64 bits.
  function automatic logic signed [63:0] sext(input logic [63:0] x, input int w);
    logic signed [63:0] t;
    t = x << (64 - w);
    return t >>> (64 - w);
  endfunction

endpackage

// File: rtl/accum_lane.sv
// One signed lane accumulator: load / add / hold, sticky overflow per frame.
// Define ACCUM_LANES_SAT_EN to clamp on overflow instead of wrapping.
module accum_lane
  import accum_pkg::*;
#(
  parameter int DATAW  = 19,
  parameter int ACCUMW = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_i,
  input  logic              add_i,
  input  logic [DATAW-1:0]  din_i,
  output logic [ACCUMW-1:0] sum_o,
  output logic              ovf_o
);

  logic signed [ACCUMW-1:0] acc_q, acc_d, ext, raw, sum;
  logic                     ovf_q, ovf_d, ovf_now;

  always_comb begin
    ext     = ACCUMW'(sext(64'(din_i), DATAW));
    raw     = acc_q + ext;
    ovf_now = (acc_q[ACCUMW-1] == ext[ACCUMW-1]) && (raw[ACCUMW-1] != acc_q[ACCUMW-1]);
`ifdef ACCUM_LANES_SAT_EN
    // On overflow the true sum lies beyond the bound on the side of the shared operand sign.
    if (ovf_now)
      sum = acc_q[ACCUMW-1] ? ACCUMW'(ACCUM_SAT_MIN(ACCUMW)) : ACCUMW'(ACCUM_SAT_MAX(ACCUMW));
    else
      sum = raw;
`else
    sum = raw;
`endif
    sum_o = load_i ? ext : sum;
    ovf_o = load_i ? 1'b0 : (ovf_q | ovf_now);
    acc_d = (load_i || add_i) ? sum_o : acc_q;
    ovf_d = (load_i || add_i) ? ovf_o : ovf_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      acc_q <= acc_d;
      ovf_q <= ovf_d;
    end
  end

endmodule

// File: rtl/accum_lanes.sv
// Multi-lane framed signed accumulator with valid/ready on both sides and sticky framing error.
// Optional saturation in each lane is enabled by defining ACCUM_LANES_SAT_EN.
module accum_lanes
  import accum_pkg::*;
#(
  parameter int DATAW  = 19,
  parameter int ACCUMW = 32,
  parameter int LANES  = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [LANES*DATAW-1:0]  data,
  input  logic                    ivalid,
  output logic                    iready,
  input  logic                    first,
  input  logic                    last,
  output logic [LANES*ACCUMW-1:0] result,
  output logic [LANES-1:0]        ovf,
  output logic                    ovalid,
  input  logic                    oready,
  output logic                    proto_err
);

  state_e                        state_q, state_d;
  logic                          accept, start, add, close;
  logic                          perr_q, perr_d, ovalid_q, ovalid_d;
  logic [LANES-1:0][ACCUMW-1:0]  sum, res_q, res_d;
  logic [LANES-1:0]              lane_ovf, ovf_q, ovf_d;

  assign iready = !ovalid_q || oready;
  assign accept = ivalid && iready;

  always_comb begin
    state_d = state_q;
    perr_d  = perr_q;
    start   = 1'b0;
    add     = 1'b0;
    close   = 1'b0;
    if (accept) begin
      if (first) begin
        // A first beat always restarts; inside a frame it also flags the truncated frame.
        start   = 1'b1;
        close   = last;
        state_d = last ? IDLE : ACCUM;
        if (state_q == ACCUM) perr_d = 1'b1;
      end else if (state_q == IDLE) begin
        perr_d = 1'b1;
      end else begin
        add   = 1'b1;
        close = last;
        if (last) state_d = IDLE;
      end
    end
    ovalid_d = close ? 1'b1 : (oready ? 1'b0 : ovalid_q);
    res_d    = close ? sum : res_q;
    ovf_d    = close ? lane_ovf : ovf_q;
  end

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    accum_lane #(.DATAW(DATAW), .ACCUMW(ACCUMW)) u_lane (
      .clk    (clk),
      .rst    (rst),
      .load_i (start),
      .add_i  (add),
      .din_i  (data[g*DATAW +: DATAW]),
      .sum_o  (sum[g]),
      .ovf_o  (lane_ovf[g])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      perr_q   <= 1'b0;
      ovalid_q <= 1'b0;
      res_q    <= '0;
      ovf_q    <= '0;
    end else begin
      state_q  <= state_d;
      perr_q   <= perr_d;
      ovalid_q <= ovalid_d;
      res_q    <= res_d;
      ovf_q    <= ovf_d;
    end
  end

  assign result    = res_q;
  assign ovf       = ovf_q;
  assign ovalid    = ovalid_q;
  assign proto_err = perr_q;

endmodule

// File: tb/tb_accum_lanes.sv
// Bench for accum_lanes: cycle model built from frame rules with plain integer arithmetic,
// directed plan cases, then randomized traffic. Honours ACCUM_LANES_SAT_EN like the RTL.
module tb_accum_lanes;
  localparam int DATAW  = 19;
  localparam int ACCUMW = 32;
  localparam int LANES  = 4;
  localparam int RW     = LANES * ACCUMW;
  localparam longint AMAX = (longint'(1) <<< (ACCUMW - 1)) - 1;

  logic                   clk = 1'b0;
  logic                   rst;
  logic [LANES*DATAW-1:0] data;
  logic                   ivalid, iready, first, last, ovalid, oready, proto_err;
  logic [RW-1:0]          result;
  logic [LANES-1:0]       ovf;

  logic [19:0] data2, result2;
  logic        iv2, ir2, f2, l2, ov2, or2, pe2;
  logic [0:0]  ovf2;

  always #5 clk = ~clk;

  accum_lanes #(.DATAW(DATAW), .ACCUMW(ACCUMW), .LANES(LANES)) u_dut (
    .clk(clk), .rst(rst), .data(data), .ivalid(ivalid), .iready(iready),
    .first(first), .last(last), .result(result), .ovf(ovf), .ovalid(ovalid),
    .oready(oready), .proto_err(proto_err)
  );

  accum_lanes #(.DATAW(20), .ACCUMW(20), .LANES(1)) u_dut20 (
    .clk(clk), .rst(rst), .data(data2), .ivalid(iv2), .iready(ir2),
    .first(f2), .last(l2), .result(result2), .ovf(ovf2), .ovalid(ov2),
    .oready(or2), .proto_err(pe2)
  );

  int n_cmp = 0, n_err = 0;

  task automatic chk(input string tag, input logic [RW-1:0] got, input logic [RW-1:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference model state
  longint m_part[LANES], m_res[LANES];
  bit     m_povf[LANES], m_ovf[LANES];
  bit     m_active, m_ovalid, m_perr;

  // Stimulus for the next edge
  int b_d[LANES];
  bit b_v, b_f, b_l, b_or, b_rst, do_cmp;

  function automatic longint fold(input longint s, output bit o);
    longint mn;
    mn = -AMAX - 1;
    o  = (s > AMAX) || (s < mn);
`ifdef ACCUM_LANES_SAT_EN
    if (s > AMAX) return AMAX;
    if (s < mn) return mn;
`else
    if (s > AMAX) return s - 2 * (AMAX + 1);
    if (s < mn) return s + 2 * (AMAX + 1);
`endif
    return s;
  endfunction

  function automatic logic [RW-1:0] exp_res();
    logic [RW-1:0] v;
    for (int i = 0; i < LANES; i++) v[i*ACCUMW +: ACCUMW] = ACCUMW'(m_res[i]);
    return v;
  endfunction

  function automatic logic [RW-1:0] exp_ovf();
    logic [RW-1:0] v;
    v = '0;
    for (int i = 0; i < LANES; i++) v[i] = m_ovf[i];
    return v;
  endfunction

  function automatic logic [RW-1:0] pk(input int a, input int b, input int c, input int d);
    logic [RW-1:0] v;
    v[0*ACCUMW +: ACCUMW] = ACCUMW'(longint'(a));
    v[1*ACCUMW +: ACCUMW] = ACCUMW'(longint'(b));
    v[2*ACCUMW +: ACCUMW] = ACCUMW'(longint'(c));
    v[3*ACCUMW +: ACCUMW] = ACCUMW'(longint'(d));
    return v;
  endfunction

  function automatic void emit();
    for (int i = 0; i < LANES; i++) begin
      m_res[i] = m_part[i];
      m_ovf[i] = m_povf[i];
    end
    m_ovalid = 1'b1;
    m_active = 1'b0;
  endfunction

  function automatic void model_edge();
    bit acc, o;
    if (b_rst) begin
      m_active = 0; m_ovalid = 0; m_perr = 0;
      for (int i = 0; i < LANES; i++) begin
        m_part[i] = 0; m_res[i] = 0; m_povf[i] = 0; m_ovf[i] = 0;
      end
      return;
    end
    acc = b_v && (!m_ovalid || b_or);
    if (m_ovalid && b_or) m_ovalid = 0;
    if (!acc) return;
    if (b_f) begin
      if (m_active) m_perr = 1;
      for (int i = 0; i < LANES; i++) begin
        m_part[i] = b_d[i]; m_povf[i] = 0;
      end
      if (b_l) emit(); else m_active = 1;
    end else if (!m_active) begin
      m_perr = 1;
    end else begin
      for (int i = 0; i < LANES; i++) begin
        m_part[i] = fold(m_part[i] + b_d[i], o);
        m_povf[i] = m_povf[i] | o;
      end
      if (b_l) emit();
    end
  endfunction

  // Called at a falling edge: drive, compare, advance model, move to next falling edge.
  task automatic step();
    rst    = b_rst;
    ivalid = b_v;
    first  = b_f;
    last   = b_l;
    oready = b_or;
    for (int i = 0; i < LANES; i++) data[i*DATAW +: DATAW] = DATAW'(b_d[i]);
    #1;
    if (do_cmp) begin
      chk("ovalid", RW'(ovalid), RW'(m_ovalid));
      chk("iready", RW'(iready), RW'(!m_ovalid || b_or));
      chk("result", result, exp_res());
      chk("ovf", RW'(ovf), exp_ovf());
      chk("proto_err", RW'(proto_err), RW'(m_perr));
    end
    model_edge();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic send(input bit f, input bit l, input int d0, input int d1, input int d2, input int d3);
    bit acc;
    acc = 0;
    b_v = 1; b_f = f; b_l = l; b_rst = 0;
    b_d[0] = d0; b_d[1] = d1; b_d[2] = d2; b_d[3] = d3;
    for (int k = 0; k < 20 && !acc; k++) begin
      acc = !m_ovalid || b_or;
      step();
    end
    if (!acc) chk("send_timeout", RW'(acc), RW'(1));
    b_v = 0;
  endtask

  task automatic idle(input int n);
    b_v = 0; b_f = 0; b_l = 0; b_rst = 0;
    for (int i = 0; i < LANES; i++) b_d[i] = 999;
    for (int k = 0; k < n; k++) step();
  endtask

  task automatic do_reset();
    b_rst = 1; b_v = 0;
    step();
    b_rst = 0;
  endtask

  task automatic beat2(input bit f, input bit l, input int d);
    iv2 = 1; f2 = f; l2 = l; data2 = 20'(d);
    idle(1);
    iv2 = 0;
  endtask

  initial begin
    iv2 = 0; f2 = 0; l2 = 0; data2 = '0; or2 = 1;
    b_or = 1; b_v = 0; b_f = 0; b_l = 0; do_cmp = 0;
    for (int i = 0; i < LANES; i++) b_d[i] = 0;
    rst = 1; ivalid = 0; first = 0; last = 0; oready = 1; data = '0;
    @(negedge clk);
    do_reset();
    do_cmp = 1;
    do_reset();
    chk("rst_result", result, '0);
    chk("rst_ovalid", RW'(ovalid), '0);
    chk("rst_iready", RW'(iready), RW'(1));
    chk("rst_perr", RW'(proto_err), '0);

    // Three-beat frame
    send(1, 0, 10, -1, 0, 32767);
    send(0, 0, 20, -2, 0, -32768);
    send(0, 1, 30, -3, 0, 16384);
    chk("tp1_ovalid", RW'(ovalid), RW'(1));
    chk("tp1_result", result, pk(60, -6, 0, 16383));
    chk("tp1_ovf", RW'(ovf), '0);
    idle(1);
    chk("tp1_pulse", RW'(ovalid), '0);

    // Single-beat frame then two-beat frame, back to back
    send(1, 1, 100, 0, 0, 0);
    chk("single", RW'(result[ACCUMW-1:0]), RW'(100));
    send(1, 0, 50, 0, 0, 0);
    send(0, 1, 75, 0, 0, 0);
    chk("b2b", RW'(result[ACCUMW-1:0]), RW'(125));
    idle(1);

    // Backpressure
    b_or = 0;
    send(1, 0, 1, 2, 3, 4);
    send(0, 1, 5, 5, 5, 5);
    b_v = 1; b_f = 1; b_l = 0;
    b_d[0] = 11; b_d[1] = 12; b_d[2] = 13; b_d[3] = 14;
    for (int k = 0; k < 3; k++) step();
    chk("bp_iready", RW'(iready), '0);
    chk("bp_hold", result, pk(6, 7, 8, 9));
    b_or = 1;
    send(1, 0, 11, 12, 13, 14);
    send(0, 1, 22, 22, 22, 22);
    chk("bp_second", result, pk(33, 34, 35, 36));
    idle(1);

    // Gap with junk data
    send(1, 0, 5, 0, 0, 0);
    idle(1);
    send(0, 1, 15, 0, 0, 0);
    chk("gap", RW'(result[ACCUMW-1:0]), RW'(20));
    idle(1);

    // Protocol errors
    send(0, 1, 42, 42, 42, 42);
    chk("drop_perr", RW'(proto_err), RW'(1));
    chk("drop_ovalid", RW'(ovalid), '0);
    send(1, 0, 7, 0, 0, 0);
    send(1, 0, 3, 0, 0, 0);
    send(0, 1, 4, 0, 0, 0);
    chk("restart", RW'(result[ACCUMW-1:0]), RW'(7));
    do_reset();
    chk("perr_clear", RW'(proto_err), '0);

    // Reset with a pending result
    b_or = 0;
    send(1, 1, 9, 9, 9, 9);
    do_reset();
    chk("rst_pend_ovalid", RW'(ovalid), '0);
    chk("rst_pend_result", result, '0);
    b_or = 1;

    // Overflow on the narrow instance
    beat2(1, 0, 262144);
    beat2(0, 1, 262144);
    chk("ovf20_flag", RW'(ovf2), RW'(1));
`ifdef ACCUM_LANES_SAT_EN
    chk("ovf20_res", RW'(result2), RW'(20'h7FFFF));
`else
    chk("ovf20_res", RW'(result2), RW'(20'h80000));
`endif
    beat2(1, 0, 262144);
    beat2(0, 0, 262144);
    beat2(0, 0, 262144);
    beat2(0, 1, -262144);
    chk("ovf20_flag2", RW'(ovf2), RW'(1));
`ifdef ACCUM_LANES_SAT_EN
    chk("ovf20_res2", RW'(result2), RW'(20'h3FFFF));
`else
    chk("ovf20_res2", RW'(result2), RW'(20'h80000));
`endif
    chk("ovf20_perr", RW'(pe2), '0);

    // Random traffic
    for (int k = 0; k < 3000; k++) begin
      b_rst = ($urandom % 300) == 0;
      b_v   = ($urandom % 4) != 0;
      b_f   = m_active ? (($urandom % 12) == 0) : (($urandom % 10) != 0);
      b_l   = ($urandom % 4) == 0;
      b_or  = ($urandom % 3) != 0;
      for (int i = 0; i < LANES; i++) b_d[i] = int'($urandom_range(0, 524287)) - 262144;
      step();
    end
    b_rst = 0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
